// File: rtl/imem_dmem_arbiter_pkg.sv
// imem_dmem_arbiter_pkg
//   Shared types and constants for the unified-memory fetch/data arbiter.
//   Contents: arb_state_t (FSM encoding), mem_cmd_t (memory command
//   bundle), ARB_STARVE_W (starvation counter width), ARB_XLEN and
//   ARB_DATA_W (bus widths).
//   Optional feature macro used by the arbiter: ARB_PERF_CNT_EN.
package imem_dmem_arbiter_pkg;

    localparam int unsigned ARB_XLEN     = 32;
    localparam int unsigned ARB_DATA_W   = 32;
    localparam int unsigned ARB_STARVE_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT_I,
        ARB_WAIT_D
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_XLEN-1:0]   addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [3:0]            wstrb;
    } mem_cmd_t;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// imem_dmem_arbiter_if
//   Bundles the fetch port, data port and memory command/response signals
//   of the arbiter.
//   Modports:
//     slave  - arbiter side (takes requests and memory responses, drives
//              grants, read responses and memory commands)
//     master - surrounding pipeline + memory side (the opposite view)
interface imem_dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    import imem_dmem_arbiter_pkg::*;

    // fetch port
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_kill;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [ARB_DATA_W-1:0] if_rdata;
    // data port
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [ARB_DATA_W-1:0] d_wdata;
    logic [3:0]            d_wstrb;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [ARB_DATA_W-1:0] d_rdata;
    // memory side
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [ARB_DATA_W-1:0] mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_rvalid;
    logic [ARB_DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_kill,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output if_req, if_addr, if_kill,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        output mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/imem_dmem_arbiter_starve_ctr.sv
// imem_dmem_arbiter_starve_ctr
//   Counts data grants issued while a fetch is waiting. Saturates at the
//   counter maximum (15) and clears on any fetch grant.
//   Ports: clk, reset (async, active-high), inc, clr,
//          cnt (current count), force_fetch (cnt >= LIMIT).
module imem_dmem_arbiter_starve_ctr
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inc,
    input  logic                    clr,
    output logic [ARB_STARVE_W-1:0] cnt,
    output logic                    force_fetch
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign force_fetch = (32'(cnt) >= LIMIT);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
//   Shares one single-ported memory between the IF fetch port and the MEM
//   data port. One transaction outstanding at a time; data beats fetch
//   unless fetch has been starved for STARVE_LIMIT data grants. A branch
//   redirect (if_kill) drops the response of an in-flight fetch.
//   Ports: clk, reset (async, active-high), bus (imem_dmem_arbiter_if.slave).
//   Optional (macro ARB_PERF_CNT_EN): if_stall_cnt, d_stall_cnt, kill_cnt
//   outputs and a WAIT-state timeout assertion of TIMEOUT_CYC cycles.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = ARB_XLEN,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT_CYC  = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_dmem_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]          if_stall_cnt,
    output logic [31:0]          d_stall_cnt,
    output logic [31:0]          kill_cnt
`endif
);

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_starve_limit
        $error("imem_dmem_arbiter: STARVE_LIMIT must be in 1..15");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("imem_dmem_arbiter: TIMEOUT_CYC must be at least 2");
    end

    arb_state_t            state;
    logic                  kill_pend;
    logic                  cur_we;
    logic [ARB_DATA_W-1:0] if_rdata_q;
    logic [ARB_DATA_W-1:0] d_rdata_q;
    logic                  force_fetch;
    logic                  grant_i;
    logic                  grant_d;
    logic                  resp_i;
    logic                  resp_d;
    logic                  if_rvalid_c;
    logic                  d_rvalid_c;
    logic [ARB_DATA_W-1:0] d_resp_data;
    mem_cmd_t              cmd;
    logic [ARB_STARVE_W-1:0] starve_cnt;

    imem_dmem_arbiter_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk         (clk),
        .reset       (reset),
        .inc         (grant_d && bus.if_req),
        .clr         (grant_i),
        .cnt         (starve_cnt),
        .force_fetch (force_fetch)
    );

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        cmd     = '0;
        if (state == ARB_IDLE) begin
            if (bus.if_req && (!bus.d_req || force_fetch)) begin
                grant_i   = 1'b1;
                cmd.addr  = ARB_XLEN'(bus.if_addr);
            end else if (bus.d_req) begin
                grant_d   = 1'b1;
                cmd.we    = bus.d_we;
                cmd.addr  = ARB_XLEN'(bus.d_addr);
                cmd.wdata = bus.d_wdata;
                cmd.wstrb = bus.d_wstrb;
            end
        end
    end

    // Responses pass through combinationally; the registered copies only
    // hold the last delivered word between pulses.
    assign resp_i      = (state == ARB_WAIT_I) && bus.mem_rvalid;
    assign resp_d      = (state == ARB_WAIT_D) && bus.mem_rvalid;
    assign if_rvalid_c = resp_i && !kill_pend && !bus.if_kill;
    assign d_rvalid_c  = resp_d;
    assign d_resp_data = cur_we ? '0 : bus.mem_rdata;

    assign bus.if_gnt    = grant_i;
    assign bus.d_gnt     = grant_d;
    assign bus.mem_req   = grant_i || grant_d;
    assign bus.mem_we    = cmd.we;
    assign bus.mem_addr  = cmd.addr[ADDR_W-1:0];
    assign bus.mem_wdata = cmd.wdata;
    assign bus.mem_wstrb = cmd.wstrb;
    assign bus.if_rvalid = if_rvalid_c;
    assign bus.if_rdata  = if_rvalid_c ? bus.mem_rdata : if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_c;
    assign bus.d_rdata   = d_rvalid_c ? d_resp_data : d_rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            kill_pend  <= 1'b0;
            cur_we     <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_i) begin
                        state     <= ARB_WAIT_I;
                        kill_pend <= bus.if_kill;
                    end else if (grant_d) begin
                        state  <= ARB_WAIT_D;
                        cur_we <= bus.d_we;
                    end
                end
                ARB_WAIT_I: begin
                    if (bus.mem_rvalid) begin
                        state     <= ARB_IDLE;
                        kill_pend <= 1'b0;
                        if (if_rvalid_c) begin
                            if_rdata_q <= bus.mem_rdata;
                        end
                    end else if (bus.if_kill) begin
                        kill_pend <= 1'b1;
                    end
                end
                ARB_WAIT_D: begin
                    if (bus.mem_rvalid) begin
                        state     <= ARB_IDLE;
                        d_rdata_q <= d_resp_data;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] wait_cyc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_stall_cnt <= '0;
            d_stall_cnt  <= '0;
            kill_cnt     <= '0;
            wait_cyc     <= '0;
        end else begin
            if (bus.if_req && !grant_i) if_stall_cnt <= if_stall_cnt + 1'b1;
            if (bus.d_req && !grant_d)  d_stall_cnt  <= d_stall_cnt + 1'b1;
            if (resp_i && !if_rvalid_c) kill_cnt     <= kill_cnt + 1'b1;
            wait_cyc <= (state == ARB_IDLE) ? '0 : wait_cyc + 1'b1;
        end
    end

    a_wait_timeout: assert property (
        @(posedge clk) disable iff (reset) (wait_cyc < TIMEOUT_CYC)
    );
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter
//   Directed bench for imem_dmem_arbiter: fetch path, priority and
//   starvation, kill handling, stores, reset mid-transaction and (with
//   ARB_PERF_CNT_EN) the performance counters. Memory responses are driven
//   directly by the steps below.
module tb_imem_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_dmem_arbiter_if #(.ADDR_W(32)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_stall_cnt;
    logic [31:0] d_stall_cnt;
    logic [31:0] kill_cnt;
`endif

    imem_dmem_arbiter #(
        .ADDR_W       (32),
        .STARVE_LIMIT (4),
        .TIMEOUT_CYC  (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .if_stall_cnt (if_stall_cnt),
        .d_stall_cnt  (d_stall_cnt),
        .kill_cnt     (kill_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge; checks 1 unit later
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.if_kill    = 1'b0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.d_wstrb    = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_if_gnt"},    32'(bus.if_gnt),    32'd0);
        check({tag, "_d_gnt"},     32'(bus.d_gnt),     32'd0);
        check({tag, "_mem_req"},   32'(bus.mem_req),   32'd0);
        check({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
        check({tag, "_d_rvalid"},  32'(bus.d_rvalid),  32'd0);
    endtask

    initial begin
        logic [5:0] exp_fetch;
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("rst");
        check("rst_if_rdata", bus.if_rdata, 32'h0);
        check("rst_d_rdata",  bus.d_rdata,  32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        reset = 1'b0;
        next_cycle();

        // ---- 1: fetch only, latency 1
        bus.if_req = 1'b1; bus.if_addr = 32'h100; settle();
        check("t1_if_gnt",   32'(bus.if_gnt),  32'd1);
        check("t1_d_gnt",    32'(bus.d_gnt),   32'd0);
        check("t1_mem_req",  32'(bus.mem_req), 32'd1);
        check("t1_mem_addr", bus.mem_addr,     32'h100);
        check("t1_mem_we",   32'(bus.mem_we),  32'd0);
        next_cycle();
        bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00A00093; settle();
        check("t1_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("t1_if_rdata",  bus.if_rdata,       32'h00A00093);
        check("t1_wait_req",  32'(bus.mem_req),   32'd0);
        next_cycle();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;
        bus.if_req = 1'b1; bus.if_addr = 32'h104; settle();
        check("t1_regrant",     32'(bus.if_gnt),    32'd1);
        check("t1_rdata_hold",  bus.if_rdata,       32'h00A00093);
        check("t1_rvalid_low",  32'(bus.if_rvalid), 32'd0);
        next_cycle();
        bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0001; settle();
        check("t1_second_rdata", bus.if_rdata, 32'h1);
        next_cycle();
        clear_inputs();

        // ---- 2: simultaneous requests, starvation limit 4 -> D D D D I D
        exp_fetch = 6'b01_0000;
        for (int k = 0; k < 6; k++) begin
            bus.if_req = 1'b1; bus.if_addr = 32'h200;
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000;
            bus.mem_rvalid = 1'b0; settle();
            check($sformatf("t2_if_gnt%0d", k), 32'(bus.if_gnt), 32'(exp_fetch[k]));
            check($sformatf("t2_d_gnt%0d", k),  32'(bus.d_gnt),  32'(!exp_fetch[k]));
            check($sformatf("t2_addr%0d", k),   bus.mem_addr, exp_fetch[k] ? 32'h200 : 32'h2000);
            next_cycle();
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1000 + 32'(k); settle();
            check($sformatf("t2_if_rv%0d", k), 32'(bus.if_rvalid), 32'(exp_fetch[k]));
            check($sformatf("t2_d_rv%0d", k),  32'(bus.d_rvalid),  32'(!exp_fetch[k]));
            if (exp_fetch[k])
                check($sformatf("t2_if_rd%0d", k), bus.if_rdata, 32'h1000 + 32'(k));
            else
                check($sformatf("t2_d_rd%0d", k), bus.d_rdata, 32'h1000 + 32'(k));
            check($sformatf("t2_starve%0d", k), 32'(dut.u_starve.cnt),
                  (k == 4) ? 32'd0 : (k == 5) ? 32'd1 : 32'(k + 1));
            next_cycle();
        end
        clear_inputs();

        // ---- 3: kill in WAIT_I, latency 3, then normal fetch
        bus.if_req = 1'b1; bus.if_addr = 32'h40; settle();
        check("t3_if_gnt", 32'(bus.if_gnt), 32'd1);
        next_cycle();
        bus.if_req = 1'b0; bus.if_kill = 1'b1; settle();
        check("t3_wait_rv", 32'(bus.if_rvalid), 32'd0);
        next_cycle();
        bus.if_kill = 1'b0;
        next_cycle();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0BAD; settle();
        check("t3_killed_rv",   32'(bus.if_rvalid), 32'd0);
        check("t3_killed_hold", bus.if_rdata,       32'h1004);
        next_cycle();
        bus.mem_rvalid = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h80; settle();
        check("t3_next_gnt",  32'(bus.if_gnt), 32'd1);
        check("t3_next_addr", bus.mem_addr,    32'h80);
        next_cycle();
        bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0013; settle();
        check("t3_next_rv",    32'(bus.if_rvalid), 32'd1);
        check("t3_next_rdata", bus.if_rdata,       32'h13);
        next_cycle();
        clear_inputs();

        // kill coincident with the response
        bus.if_req = 1'b1; bus.if_addr = 32'h84; settle();
        next_cycle();
        bus.if_req = 1'b0; bus.if_kill = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77; settle();
        check("t3_same_cycle_kill", 32'(bus.if_rvalid), 32'd0);
        next_cycle();
        clear_inputs();
        // kill in the granting IDLE cycle
        bus.if_req = 1'b1; bus.if_addr = 32'h88; bus.if_kill = 1'b1; settle();
        check("t3_idle_kill_gnt", 32'(bus.if_gnt), 32'd1);
        next_cycle();
        bus.if_req = 1'b0; bus.if_kill = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h78; settle();
        check("t3_idle_kill_rv", 32'(bus.if_rvalid), 32'd0);
        next_cycle();
        clear_inputs();
        // kill does not affect a load
        bus.d_req = 1'b1; bus.d_addr = 32'h2100; settle();
        next_cycle();
        bus.d_req = 1'b0; bus.if_kill = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_CAFE; settle();
        check("t3_load_kill_rv", 32'(bus.d_rvalid), 32'd1);
        check("t3_load_kill_rd", bus.d_rdata,       32'hCAFE);
        next_cycle();
        clear_inputs();

        // ---- 4: store
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h3000;
        bus.d_wdata = 32'hDEADBEEF; bus.d_wstrb = 4'h3; settle();
        check("t4_d_gnt",  32'(bus.d_gnt),     32'd1);
        check("t4_req",    32'(bus.mem_req),   32'd1);
        check("t4_we",     32'(bus.mem_we),    32'd1);
        check("t4_addr",   bus.mem_addr,       32'h3000);
        check("t4_wdata",  bus.mem_wdata,      32'hDEADBEEF);
        check("t4_wstrb",  32'(bus.mem_wstrb), 32'h3);
        next_cycle();
        bus.d_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_5555; settle();
        check("t4_d_rv",   32'(bus.d_rvalid),  32'd1);
        check("t4_d_rd",   bus.d_rdata,        32'h0);
        check("t4_if_rv",  32'(bus.if_rvalid), 32'd0);
        next_cycle();
        clear_inputs(); settle();
        check("t4_d_rd_hold", bus.d_rdata, 32'h0);

        // ---- 5: reset in WAIT_D, late response in IDLE
        next_cycle();
        bus.d_req = 1'b1; bus.d_addr = 32'h4000; settle();
        check("t5_d_gnt", 32'(bus.d_gnt), 32'd1);
        next_cycle();
        bus.d_req = 1'b0; reset = 1'b1; settle();
        check_quiet("t5_in_rst");
        next_cycle();
        reset = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0077; settle();
        check_quiet("t5_stale");
        check("t5_d_rd", bus.d_rdata,  32'h0);
        check("t5_if_rd", bus.if_rdata, 32'h0);
        next_cycle();
        bus.mem_rvalid = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h300; settle();
        check("t5_gnt",  32'(bus.if_gnt), 32'd1);
        check("t5_addr", bus.mem_addr,    32'h300);
        next_cycle();
        bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_1234; settle();
        check("t5_rv", 32'(bus.if_rvalid), 32'd1);
        check("t5_rd", bus.if_rdata,       32'h1234);
        next_cycle();
        clear_inputs();

`ifdef ARB_PERF_CNT_EN
        // ---- 6: counters from a fresh reset
        reset = 1'b1; next_cycle(); reset = 1'b0;
        bus.d_req = 1'b1; bus.d_addr = 32'h5000; settle();           // c0 grant D
        next_cycle();
        bus.if_req = 1'b1; bus.if_addr = 32'h400; settle();          // c1 stall
        next_cycle();
        bus.mem_rvalid = 1'b1; settle();                             // c2 stall
        next_cycle();
        bus.mem_rvalid = 1'b0; settle();                             // c3 D wins, stall
        next_cycle();
        bus.d_req = 1'b0; settle();                                  // c4 stall
        next_cycle();
        bus.mem_rvalid = 1'b1; settle();                             // c5 stall
        next_cycle();
        bus.mem_rvalid = 1'b0; settle();                             // c6 I granted
        next_cycle();
        bus.if_req = 1'b0; bus.if_kill = 1'b1; settle();             // c7 kill
        next_cycle();
        bus.if_kill = 1'b0; bus.mem_rvalid = 1'b1; settle();         // c8 dropped
        next_cycle();
        clear_inputs(); settle();
        check("t6_if_stall", if_stall_cnt, 32'd5);
        check("t6_d_stall",  d_stall_cnt,  32'd2);
        check("t6_kill",     kill_cnt,     32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
Shares one single-ported unified memory between the IF-stage fetch port and the MEM-stage data port. It uses a one-outstanding-transaction FSM with data-over-fetch priority and an anti-starvation counter. It also kills in-flight wrong-path fetches on branch redirect. It sits between the pipeline stages and the memory model or bus bridge.

Parameters:
ADDR_W, 32, byte-address width (tied to XLEN from riscv_pkg)
STARVE_LIMIT, 4, consecutive data grants while a fetch is pending before fetch is forced to win; range 1..15
TIMEOUT_CYC, 64, used only when ARB_PERF_CNT_EN is defined (reserved; no behaviour otherwise)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDR_W  fetch byte address, word aligned
if_kill  in  1  branch_taken from EX; discard any in-flight fetch
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid, one-cycle pulse
if_rdata  out  32  instruction word
d_req  in  1  data request, held until d_gnt
d_we  in  1  1 = store
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data
d_wstrb  in  4  byte enables
d_gnt  out  1  data accepted this cycle
d_rvalid  out  1  load data or store ack, one-cycle pulse
d_rdata  out  32  load data; 0 for stores
mem_req  out  1  memory command strobe, one cycle per transaction
mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/32/4  command fields, valid when mem_req=1
mem_rvalid  in  1  memory response or ack, arbitrary latency of 1 or more cycles
mem_rdata  in  32  response data

Behaviour:
- FSM states are IDLE, WAIT_I and WAIT_D. Reset puts the FSM in IDLE, clears starve_cnt and kill_pend, and drives all outputs to 0.
- Grants are issued in IDLE only.
  - if_gnt and d_gnt are combinational from IDLE and the requests.
  - mem_req and the command fields are driven combinationally with the grant in the same cycle.
  - The FSM moves to WAIT_I or WAIT_D on that edge.
- Priority:
  - Data wins when both requests are present, unless starve_cnt is STARVE_LIMIT or more, in which case fetch wins.
  - starve_cnt increments on each data grant while if_req=1, saturating at 15.
  - starve_cnt clears on any fetch grant.
- WAIT_x: mem_req=0. On mem_rvalid, route mem_rdata to the matching port, pulse its rvalid, and return to IDLE. The earliest next grant is the following cycle, so peak throughput is one transaction per 2 cycles.
- Kill:
  - if_kill in WAIT_I, or in the IDLE cycle that grants fetch, sets kill_pend.
  - The matching mem_rvalid is consumed with if_rvalid held at 0, then kill_pend clears.
  - if_kill arriving in the same cycle as mem_rvalid also suppresses that response.
  - if_kill has no effect on data transactions.
- mem_rvalid seen in IDLE is ignored (stale response after reset); no output changes.
- Reset mid-transaction: the FSM returns to IDLE immediately and the in-flight response is dropped by the IDLE rule above.
- d_rdata is 0 on store acks. if_rdata and d_rdata hold their last value when the matching rvalid=0.

Optional Feature:
ARB_PERF_CNT_EN:
- Defined: adds outputs if_stall_cnt[31:0], d_stall_cnt[31:0] and kill_cnt[31:0].
  - if_stall_cnt counts cycles with if_req && !if_gnt.
  - d_stall_cnt counts cycles with d_req && !d_gnt.
  - kill_cnt counts suppressed fetch responses.
  - All three wrap at 2^32 and reset to 0.
- Defined, additionally: a WAIT_x lasting TIMEOUT_CYC cycles triggers an SVA assertion failure (simulation only).
- Undefined: no such ports, counters or assertion.

Decomposition:
- riscv_pkg additions:
  - arb_state_t enum {ARB_IDLE, ARB_WAIT_I, ARB_WAIT_D}.
  - mem_cmd_t struct {we, addr, wdata, wstrb}.
  - Constant ARB_STARVE_W=4.
- One natural sub-module, arb_starve_ctr: saturating counter with a clear input and a "force fetch" compare output.

Test Plan:
1. Fetch only, if_addr=0x100, mem latency 1 → if_gnt at c0, mem_req with addr 0x100 at c0, if_rvalid with rdata at c1, next grant possible at c2.
2. if_req and d_req (load 0x2000) asserted together and held, STARVE_LIMIT=4 → grant order D,D,D,D,I, then D resumes; starve_cnt=0 after the fetch grant.
3. Fetch granted at 0x40, if_kill pulsed in WAIT_I, memory latency 3 → mem_rvalid consumed, if_rvalid stays 0, and the next fetch (0x80) response is delivered normally.
4. Store d_we=1, wstrb=0x3, wdata=0xDEADBEEF → mem fields match, d_rvalid pulses with d_rdata=0, if_rvalid does not pulse.
5. Reset asserted in WAIT_D, then released with a late mem_rvalid arriving in IDLE → no rvalid pulses, all outputs 0, the next grant behaves normally.
6. With ARB_PERF_CNT_EN: fetch blocked 5 cycles by data traffic, plus 1 kill → if_stall_cnt=5, kill_cnt=1.
